// File: rtl/pw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pw_pkg                                                               |
// | State encoding and default sizing for the trigger-clock phase        |
// | sequencer.                                                           |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package pw_pkg;

  typedef logic [2:0] ps_state_t;

  localparam ps_state_t PS_IDLE  = 3'd0;
  localparam ps_state_t PS_CHECK = 3'd1;
  localparam ps_state_t PS_STEP  = 3'd2;
  localparam ps_state_t PS_WAIT  = 3'd3;
  localparam ps_state_t PS_ERROR = 3'd4;

  localparam int PW_DEF_PHASE_WIDTH   = 10;
  localparam int PW_DEF_PHASE_MAX     = 448;
  localparam int PW_DEF_TIMEOUT       = 64;
  localparam int PW_DEF_TIMEOUT_WIDTH = 7;

endpackage
`default_nettype wire

// File: rtl/pw_phase_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pw_phase_ctrl                                                        |
// | Steps the trigger MMCM fine phase one psen at a time until the       |
// | applied phase matches the clamped target; supervises psdone.         |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module pw_phase_ctrl
  import pw_pkg::*;
#(
  parameter int pPHASE_WIDTH   = PW_DEF_PHASE_WIDTH,
  parameter int pPHASE_MAX     = PW_DEF_PHASE_MAX,
  parameter int pTIMEOUT       = PW_DEF_TIMEOUT,
  parameter int pTIMEOUT_WIDTH = PW_DEF_TIMEOUT_WIDTH
) (
  input  logic                           usb_clk,
  input  logic                           reset_i,
  input  logic signed [pPHASE_WIDTH-1:0] I_target,
  input  logic                           I_update,
  input  logic                           I_locked,
  input  logic                           I_psdone,
  output logic                           O_psen,
  output logic                           O_psincdec,
  output logic signed [pPHASE_WIDTH-1:0] O_current,
  output logic                           O_busy,
  output logic                           O_error
);

  localparam logic signed [pPHASE_WIDTH-1:0]   C_MAX      = pPHASE_WIDTH'(pPHASE_MAX);
  localparam logic signed [pPHASE_WIDTH-1:0]   C_MIN      = -C_MAX;
  localparam logic signed [pPHASE_WIDTH-1:0]   C_ONE      = pPHASE_WIDTH'(1);
  localparam logic        [pTIMEOUT_WIDTH-1:0] C_TMO_ONE  = pTIMEOUT_WIDTH'(1);
  localparam logic        [pTIMEOUT_WIDTH-1:0] C_TMO_LAST = pTIMEOUT_WIDTH'(pTIMEOUT - 1);

  ps_state_t                          r_state;
  ps_state_t                          w_state_next;
  logic signed [pPHASE_WIDTH-1:0]     r_target;
  logic signed [pPHASE_WIDTH-1:0]     w_target_next;
  logic signed [pPHASE_WIDTH-1:0]     w_target_clamped;
  logic signed [pPHASE_WIDTH-1:0]     r_current;
  logic signed [pPHASE_WIDTH-1:0]     w_current_next;
  logic        [pTIMEOUT_WIDTH-1:0]   r_tmo;
  logic        [pTIMEOUT_WIDTH-1:0]   w_tmo_next;
  logic                               r_locked_q;
  logic                               w_lock_rise;
  logic                               r_psen;
  logic                               w_psen_next;
  logic                               r_psincdec;
  logic                               w_psincdec_next;
  logic                               r_busy;
  logic                               w_busy_next;
  logic                               r_error;
  logic                               w_error_next;

  assign w_lock_rise = I_locked & ~r_locked_q;

  always_comb begin
    w_target_clamped = I_target;
    if (I_target > C_MAX) begin
      w_target_clamped = C_MAX;
    end else if (I_target < C_MIN) begin
      w_target_clamped = C_MIN;
    end
  end

  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= PS_IDLE;
      r_target   <= '0;
      r_current  <= '0;
      r_tmo      <= '0;
      r_locked_q <= 1'b0;
      r_psen     <= 1'b0;
      r_psincdec <= 1'b0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_target   <= w_target_next;
      r_current  <= w_current_next;
      r_tmo      <= w_tmo_next;
      r_locked_q <= I_locked;
      r_psen     <= w_psen_next;
      r_psincdec <= w_psincdec_next;
      r_busy     <= w_busy_next;
      r_error    <= w_error_next;
    end
  end

  // An update landing in CHECK re-runs the compare so a fresh target is never skipped.
  always_comb begin
    w_state_next = r_state;
    if (!I_locked) begin
      w_state_next = PS_IDLE;
    end else begin
      case (r_state)
        PS_IDLE:  if (I_update || w_lock_rise) w_state_next = PS_CHECK;
        PS_CHECK: begin
          if (I_update) begin
            w_state_next = PS_CHECK;
          end else if (r_current == r_target) begin
            w_state_next = PS_IDLE;
          end else begin
            w_state_next = PS_STEP;
          end
        end
        PS_STEP:  w_state_next = PS_WAIT;
        PS_WAIT: begin
          if (I_psdone) begin
            w_state_next = PS_CHECK;
          end else if (r_tmo == C_TMO_LAST) begin
            w_state_next = PS_ERROR;
          end
        end
        PS_ERROR: if (I_update) w_state_next = PS_CHECK;
        default:  w_state_next = PS_IDLE;
      endcase
    end
  end

  always_comb begin
    w_target_next   = I_update ? w_target_clamped : r_target;
    w_psen_next     = (w_state_next == PS_STEP);
    w_psincdec_next = r_psincdec;
    w_current_next  = r_current;
    w_tmo_next      = r_tmo;
    w_error_next    = r_error;

    if (r_state == PS_CHECK && w_state_next == PS_STEP) begin
      w_psincdec_next = (r_target > r_current);
    end

    // Losing lock resets the MMCM phase, so the applied count restarts at zero.
    if (!I_locked) begin
      w_current_next = '0;
    end else if (r_state == PS_WAIT && I_psdone) begin
      w_current_next = r_psincdec ? (r_current + C_ONE) : (r_current - C_ONE);
    end

    if (r_state == PS_STEP) begin
      w_tmo_next = C_TMO_ONE;
    end else if (r_state == PS_WAIT) begin
      w_tmo_next = r_tmo + C_TMO_ONE;
    end

    if (r_state == PS_WAIT && w_state_next == PS_ERROR) begin
      w_error_next = 1'b1;
    end else if (r_state == PS_ERROR && I_update && I_locked) begin
      w_error_next = 1'b0;
    end

    w_busy_next = ((w_state_next != PS_IDLE) && (w_state_next != PS_ERROR)) ||
                  (w_current_next != w_target_next);
  end

  assign O_psen     = r_psen;
  assign O_psincdec = r_psincdec;
  assign O_current  = r_current;
  assign O_busy     = r_busy;
  assign O_error    = r_error;

endmodule
`default_nettype wire
